// File: rtl/frame_signature_pkg.sv
// Shared types and constants for the frame signature block.
package frame_signature_pkg;

   localparam logic [15:0] CRC_POLY_CCITT = 16'h1021;
   localparam logic [15:0] CRC_INIT_CCITT = 16'hFFFF;

   typedef logic [15:0] sig_t;

   typedef enum logic [0:0] {
      StIdle,
      StAccum
   } state_e;

   // One MSB-first CRC-16/CCITT bit step; reference model for a single input bit.
   function automatic sig_t crc16_step(sig_t crc, logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY_CCITT : 16'h0000);
   endfunction

endpackage

// File: rtl/frame_signature_if.sv
// Host-side result handshake of the frame signature block.
interface frame_signature_if;
   import frame_signature_pkg::*;

   sig_t       sig_o;
   logic [7:0] frame_seq_o;
   logic       pix_mismatch_o;
   logic       sig_valid_o;
   logic       sig_ack_i;
   logic       overrun_o;

   // master: the signature block producing results
   modport master (
      output sig_o,
      output frame_seq_o,
      output pix_mismatch_o,
      output sig_valid_o,
      output overrun_o,
      input  sig_ack_i
   );

   // slave: the host reading and acknowledging results
   modport slave (
      input  sig_o,
      input  frame_seq_o,
      input  pix_mismatch_o,
      input  sig_valid_o,
      input  overrun_o,
      output sig_ack_i
   );

endinterface

// File: rtl/frame_signature_crc16_pixel.sv
// Combinational next-CRC over one whole pixel word, bits absorbed MSB first.
module crc16_pixel
   import frame_signature_pkg::*;
#(
   parameter int unsigned PIXEL_BITS = 6,
   parameter logic [15:0] CRC_POLY   = CRC_POLY_CCITT
) (
   input  sig_t                  crc_i,
   input  logic [PIXEL_BITS-1:0] pixel_i,
   output sig_t                  crc_o
);

   sig_t crc_v;
   logic fb;

   // Unrolled bit-serial CRC: one shift/xor stage per pixel bit.
   always_comb begin
      crc_v = crc_i;
      fb    = 1'b0;
      for (int i = PIXEL_BITS - 1; i >= 0; i--) begin
         fb    = crc_v[15] ^ pixel_i[i];
         crc_v = {crc_v[14:0], 1'b0};
         if (fb) begin
            crc_v = crc_v ^ CRC_POLY;
         end
      end
      crc_o = crc_v;
   end

endmodule

// File: rtl/frame_signature.sv
// Per-frame CRC-16 signature and active-pixel count of the pixel stream,
// reported to a host through a valid/ack handshake.
module frame_signature
   import frame_signature_pkg::*;
#(
   parameter int unsigned PIXEL_BITS      = 6,
   parameter logic [15:0] CRC_POLY        = CRC_POLY_CCITT,
   parameter logic [15:0] CRC_INIT        = CRC_INIT_CCITT,
   parameter int unsigned EXPECTED_PIXELS = 480000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic [PIXEL_BITS-1:0] pixel_i,
   input  logic                  blank_i,
   input  logic                  next_frame_i,
   frame_signature_if.master     host
);

   localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECTED_PIXELS);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // FSM
   state_e state_q, state_d;
   logic   arm;         // idle -> accumulate at a frame boundary
   logic   take_pix;    // absorb this cycle's pixel
   logic   frame_done;  // current frame completes this cycle

   // Accumulator
   sig_t             crc_q, crc_d;
   sig_t             crc_next;
   sig_t             crc_fin;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] cnt_fin;

   // Result
   logic [7:0] seq_q, seq_d;
   sig_t       sig_q, sig_d;
   logic [7:0] fseq_q, fseq_d;
   logic       mism_q, mism_d;
   logic       valid_q, valid_d;
   logic       ovr_q, ovr_d;
   logic       load;

   crc16_pixel #(
      .PIXEL_BITS (PIXEL_BITS),
      .CRC_POLY   (CRC_POLY)
   ) u_crc (
      .crc_i   (crc_q),
      .pixel_i (pixel_i),
      .crc_o   (crc_next)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: enable is only looked at on a frame boundary.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (next_frame_i && enable_i) begin
               state_d = StAccum;
            end
         end
         StAccum: begin
            if (next_frame_i) begin
               state_d = enable_i ? StAccum : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM decoded controls.
   always_comb begin
      arm        = 1'b0;
      take_pix   = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            arm = next_frame_i && enable_i;
         end
         StAccum: begin
            take_pix   = !blank_i;
            frame_done = next_frame_i;
         end
         default: ;
      endcase
   end

   // Frame totals including a pixel that coincides with the boundary pulse.
   always_comb begin
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      crc_fin = take_pix ? crc_next : crc_q;
      cnt_fin = take_pix ? cnt_inc : cnt_q;
   end

   // Accumulator next state: reload on every boundary that starts a frame.
   always_comb begin
      crc_d = crc_q;
      cnt_d = cnt_q;
      if (arm || frame_done) begin
         crc_d = CRC_INIT;
         cnt_d = '0;
      end else if (take_pix) begin
         crc_d = crc_next;
         cnt_d = cnt_inc;
      end
   end

   // Accumulator registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         crc_q <= CRC_INIT;
         cnt_q <= '0;
      end else begin
         crc_q <= crc_d;
         cnt_q <= cnt_d;
      end
   end

   // Result next state: the oldest unacked result wins, newer ones are dropped.
   always_comb begin
      load    = frame_done && (!valid_q || host.sig_ack_i);
      seq_d   = seq_q;
      sig_d   = sig_q;
      fseq_d  = fseq_q;
      mism_d  = mism_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (frame_done) begin
         // Dropped frames still consume a sequence number.
         seq_d = seq_q + 8'd1;
         if (load) begin
            sig_d   = crc_fin;
            fseq_d  = seq_q + 8'd1;
            mism_d  = (cnt_fin != EXP_CNT);
            valid_d = 1'b1;
            ovr_d   = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && host.sig_ack_i) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // Result registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seq_q   <= 8'd0;
         sig_q   <= '0;
         fseq_q  <= 8'd0;
         mism_q  <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         seq_q   <= seq_d;
         sig_q   <= sig_d;
         fseq_q  <= fseq_d;
         mism_q  <= mism_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign host.sig_o          = sig_q;
   assign host.frame_seq_o    = fseq_q;
   assign host.pix_mismatch_o = mism_q;
   assign host.sig_valid_o    = valid_q;
   assign host.overrun_o      = ovr_q;

endmodule

// File: doc/frame_signature.md
Name: frame_signature

Overview:
- Downstream observer of the SVGA pixel generator. Taps the final per-pixel colour stream together with the blank and frame-boundary strobes.
- For every frame it computes a CRC-16 signature over the active pixels and counts them.
- It presents the signature, an active-pixel count check and a frame sequence number to a host reader through a valid/ack handshake.
- Used for silicon self-test and for golden-frame comparison in regression.

Parameters:
- PIXEL_BITS, 6, width of the colour word (rrggbb).
- CRC_POLY, 16'h1021, CRC-16/CCITT polynomial, MSB-first, no reflection, no final XOR.
- CRC_INIT, 16'hFFFF, accumulator value at the start of each frame.
- EXPECTED_PIXELS, 480000, active pixels per frame (800x600).
- CNT_W, 20, width of the active-pixel counter; must hold EXPECTED_PIXELS+1.

Ports:
- clk_i  in  1  pixel clock (40 MHz).
- rst_i  in  1  synchronous reset, active-high.
- enable_i  in  1  request to capture; sampled only at frame boundaries.
- pixel_i  in  PIXEL_BITS  final colour of the current cycle.
- blank_i  in  1  high when hblank or vblank is active; pixel is ignored.
- next_frame_i  in  1  one-cycle pulse marking the end of a frame.
- sig_o  out  16  latched CRC of the last reported frame.
- frame_seq_o  out  8  sequence number of the reported frame; wraps 255->0.
- pix_mismatch_o  out  1  reported frame's active count != EXPECTED_PIXELS.
- sig_valid_o  out  1  result available.
- sig_ack_i  in  1  host consumes the result; effective only while sig_valid_o=1.
- overrun_o  out  1  a completed frame was dropped because the previous result was unacked.

Behaviour:
- Reset is synchronous, active-high. It has priority over everything, including a mid-frame reset.
  - Clears: state=IDLE, accumulator=CRC_INIT, counter=0, seq=0.
  - Output reset values: sig_o=0, frame_seq_o=0, pix_mismatch_o=0, sig_valid_o=0, overrun_o=0.
- FSM, two states:
  - IDLE: nothing is accumulated. On next_frame_i with enable_i=1, go to ACCUM with accumulator=CRC_INIT and counter=0.
  - ACCUM: each cycle with blank_i=0, absorb pixel_i into the CRC and increment the counter.
    - The absorbing order is the PIXEL_BITS bits of pixel_i, MSB first; per bit: fb=crc[15]^bit; crc=crc<<1; if fb, crc^=CRC_POLY.
    - Counter saturates at 2^CNT_W-1.
  - On next_frame_i in ACCUM, the frame completes.
    - If blank_i=0 in that same cycle, that pixel is included first.
    - The result goes to the result logic.
    - Accumulator and counter reload to CRC_INIT/0.
    - Next state is ACCUM if enable_i=1, else IDLE.
- A partial frame (enable raised mid-frame) never produces a result. Deasserting enable_i mid-frame does not abort the current frame.
- Result logic, one cycle latency: outputs update on the clock edge that samples next_frame_i.
  - Every completed frame increments the internal sequence number, including dropped frames.
  - If sig_valid_o=0, or sig_ack_i=1 in the same cycle, load:
    - sig_o=final CRC;
    - frame_seq_o=new sequence number (first captured frame after reset reports 1);
    - pix_mismatch_o=(count!=EXPECTED_PIXELS);
    - sig_valid_o=1.
  - Otherwise keep the old result (oldest wins) and set overrun_o=1.
  - Ack with no completion: sig_valid_o=0, overrun_o=0. Output data holds its value.
  - Ack and completion in the same cycle: new result loaded, valid stays 1, no overrun.
- Arithmetic: the CRC is exactly 16 bits and the counter compare is unsigned. The sequence wraps modulo 256.

Decomposition:
- Package frame_signature_pkg holds:
  - CRC_POLY_CCITT and CRC_INIT_CCITT constants;
  - a typedef for the 16-bit signature;
  - a function crc16_step(crc, bit) for the bench model.
- One sub-module, crc16_pixel: a combinational 6-bit unrolled next-CRC over PIXEL_BITS, instantiated once in the datapath.

Test Plan:
- Reset: assert rst_i mid-frame for 1 cycle -> all outputs 0, state IDLE; the following next_frame_i pulse produces no result.
- Single pixel (EXPECTED_PIXELS=1, enable_i=1): arm with a pulse, one unblanked pixel 6'b000000, then a pulse -> next cycle sig_o=16'h387C, frame_seq_o=1, pix_mismatch_o=0, sig_valid_o=1.
- Empty frame (EXPECTED_PIXELS=1): arm, pulse with no unblanked cycles -> sig_o=16'hFFFF, pix_mismatch_o=1.
- Overrun: complete two frames without ack -> sig_o/frame_seq_o keep frame 1 values, overrun_o=1. Then ack -> sig_valid_o=0, overrun_o=0. Third frame reports frame_seq_o=3.
- Ack collision: sig_ack_i high in the completion cycle while valid -> new frame loaded, sig_valid_o stays 1, overrun_o=0.
- Full 800x600 from the pixel generator with a fixed background -> pix_mismatch_o=0 and sig_o matches the package-function model. Enable raised mid-frame -> only the next full frame reports.
